// File: rtl/tdm_demux_if.sv
// TDM receiver bus: serial sync/din in, word and frame results out.
// Latency: n/a (wiring only).
// Backpressure: none; every output is a pulse or a held register.
interface tdm_demux_if #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int CW   = 2
);
  logic              sync;
  logic              din;
  logic [W-1:0]      word_out;
  logic [CW-1:0]     word_ch;
  logic              word_valid;
  logic [N_CH*W-1:0] ch_data;
  logic              frame_valid;
  logic              frame_err;
  logic              locked;

  modport master (
    output sync, din,
    input  word_out, word_ch, word_valid, ch_data, frame_valid, frame_err, locked
  );

  modport slave (
    input  sync, din,
    output word_out, word_ch, word_valid, ch_data, frame_valid, frame_err, locked
  );
endinterface

// File: rtl/tdm_demux.sv
// Frame-aligned TDM deserialiser: serial bits to per-slot words and an atomic frame bus.
// Latency: word_valid/frame_valid/frame_err one clock after the edge sampling the deciding bit.
// Backpressure: none; the line runs at one bit per clock and results must be taken as they pulse.
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int CW   = 2
) (
  input  logic       clk,
  input  logic       rst,
  tdm_demux_if.slave bus
);
  localparam int BW = $clog2(W);
  localparam logic [BW-1:0] LAST_BIT  = BW'(W - 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(N_CH - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [CW-1:0]     slot_cnt, slot_cnt_nxt;
  logic [W-2:0]      shift_q, shift_nxt;
  logic [N_CH*W-1:0] stage_q, stage_nxt;
  logic [W-1:0]      word_q, word_nxt;
  logic [CW-1:0]     ch_q, ch_nxt;
  logic [N_CH*W-1:0] frame_q, frame_nxt;
  logic              wv_q, wv_nxt;
  logic              fv_q, fv_nxt;
  logic              fe_q, fe_nxt;

  logic [W-1:0]      word_in;
  logic              at_boundary;
  logic              word_done;

  assign word_in     = {shift_q, bus.din};
  // In RECV, bit 0 / slot 0 is only reachable right after a frame completed.
  assign at_boundary = (bit_cnt == '0) && (slot_cnt == '0);
  assign word_done   = (bit_cnt == LAST_BIT);

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    slot_cnt_nxt = slot_cnt;
    shift_nxt    = shift_q;
    stage_nxt    = stage_q;
    word_nxt     = word_q;
    ch_nxt       = ch_q;
    frame_nxt    = frame_q;
    wv_nxt       = 1'b0;
    fv_nxt       = 1'b0;
    fe_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.sync) begin
          state_nxt    = RECV;
          shift_nxt    = '0;
          shift_nxt[0] = bus.din;
          bit_cnt_nxt  = BW'(1);
          slot_cnt_nxt = '0;
        end
      end

      RECV: begin
        if (at_boundary) begin
          if (bus.sync) begin
            shift_nxt    = '0;
            shift_nxt[0] = bus.din;
            bit_cnt_nxt  = BW'(1);
            slot_cnt_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (bus.sync) begin
          // Misplaced sync: drop the partial frame and realign on this bit.
          fe_nxt       = 1'b1;
          stage_nxt    = '0;
          shift_nxt    = '0;
          shift_nxt[0] = bus.din;
          bit_cnt_nxt  = BW'(1);
          slot_cnt_nxt = '0;
        end else begin
          shift_nxt = word_in[W-2:0];
          if (word_done) begin
            bit_cnt_nxt = '0;
            word_nxt    = word_in;
            ch_nxt      = slot_cnt;
            wv_nxt      = 1'b1;
            for (int k = 0; k < N_CH; k++) begin
              if (slot_cnt == CW'(k)) begin
                stage_nxt[k*W +: W] = word_in;
              end
            end
            if (slot_cnt == LAST_SLOT) begin
              frame_nxt    = stage_nxt;
              fv_nxt       = 1'b1;
              slot_cnt_nxt = '0;
            end else begin
              slot_cnt_nxt = slot_cnt + CW'(1);
            end
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      slot_cnt <= '0;
      shift_q  <= '0;
      stage_q  <= '0;
      word_q   <= '0;
      ch_q     <= '0;
      frame_q  <= '0;
      wv_q     <= 1'b0;
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      slot_cnt <= slot_cnt_nxt;
      shift_q  <= shift_nxt;
      stage_q  <= stage_nxt;
      word_q   <= word_nxt;
      ch_q     <= ch_nxt;
      frame_q  <= frame_nxt;
      wv_q     <= wv_nxt;
      fv_q     <= fv_nxt;
      fe_q     <= fe_nxt;
    end
  end

  assign bus.word_out    = word_q;
  assign bus.word_ch     = ch_q;
  assign bus.word_valid  = wv_q;
  assign bus.ch_data     = frame_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_err   = fe_q;
  assign bus.locked      = (state == RECV);
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receiving end of the team's time-division multiplexed serial link: the transmitter muxes N_CH channels of W-bit words onto one wire, one bit per clock, MSB first, and marks each frame's first bit with a sync pulse.
- This block tracks frame alignment and shifts bits into per-slot words.
- It presents each completed word with its channel index and publishes the whole frame atomically on a parallel bus.
- It flags sync errors and recovers alignment.

Parameters:
N_CH, 4, number of channels (time slots) per frame, >= 2
W, 8, bits per channel word, >= 2
CW, 2, width of channel index, must be >= ceil(log2(N_CH))

Ports:
clk  input  1  rising-edge clock, one serial bit per cycle
rst  input  1  asynchronous, active-high reset
sync  input  1  high coincident with bit 0 (MSB of channel 0) of a frame
din  input  1  serial data bit, sampled every rising edge of clk
word_out  output  W  last completed channel word
word_ch  output  CW  slot index of word_out
word_valid  output  1  one-cycle pulse: word_out/word_ch are new
ch_data  output  N_CH*W  full frame; channel k occupies bits [k*W+W-1 : k*W]
frame_valid  output  1  one-cycle pulse: ch_data updated with a complete frame
frame_err  output  1  one-cycle pulse: sync seen at a position other than a frame boundary
locked  output  1  high while in RECV state

Behaviour:
- Reset (async, rst=1): state IDLE; bit_cnt=0, slot_cnt=0, shift register=0, staging registers=0. Outputs: word_out=0, word_ch=0, ch_data=0, word_valid=0, frame_valid=0, frame_err=0, locked=0.
- Reset mid-frame discards all partial data. ch_data returns to 0.
- States: IDLE, RECV.
- IDLE:
  - din is ignored unless sync=1.
  - On sync=1: din is captured as the MSB of slot 0, bit_cnt=1, slot_cnt=0, go to RECV.
- RECV, one bit per cycle:
  - shift = {shift[W-2:0], din}.
  - bit_cnt increments; it wraps to 0 after W-1.
- Word completion (bit_cnt==W-1 at the sampling edge):
  - At that edge the completed word {shift[W-2:0], din} goes to word_out, slot_cnt goes to word_ch, and it is written into staging slot slot_cnt.
  - word_valid=1 in the following cycle.
  - Latency: 1 clock from the edge sampling the LSB to the visible word_valid.
  - slot_cnt then increments.
- Frame completion (last bit of slot N_CH-1):
  - At the same edge as the word write, ch_data is loaded with all staging slots, including the word just finished.
  - frame_valid pulses in the same cycle as that word's word_valid.
  - ch_data holds until the next complete frame; partial frames never alter it.
  - Next edge: sync=1 starts the next frame at bit 0 and the block stays in RECV (back-to-back frames, no gap). sync=0 returns to IDLE, locked drops, and that din bit is discarded.
- Sync inside a frame (RECV, sync=1 while not at frame bit 0):
  - frame_err pulses the next cycle.
  - Staging data for the frame is discarded; ch_data is unchanged.
  - The current din is taken as bit 0 of a new frame (bit_cnt=1, slot_cnt=0), and the block stays in RECV.
  - If that same edge also completes a word, no word_valid is produced for it.
- Only one frame_valid or frame_err per frame. word_valid never occurs in IDLE.

Test Plan:
- Reset: hold rst=1 with random din/sync -> all outputs 0 and locked=0. Release rst; din toggling without sync -> no pulses, locked=0.
- Single frame: N_CH=4, W=8; sync with first bit, stream A5,3C,FF,00 MSB-first -> word_valid on cycles 9,17,25,33 with (ch,word)=(0,A5),(1,3C),(2,FF),(3,00). frame_valid at cycle 33 with ch_data=32'h00FF3CA5. IDLE and locked=0 after cycle 33.
- Back-to-back frames: second sync at bit 33 carrying 01,02,03,04 -> locked stays 1. Second frame_valid 32 cycles after the first, ch_data=32'h04030201.
- Mid-frame sync: sync reasserted at bit 12 of a frame -> frame_err pulse at cycle 13. ch_data keeps its old value. The new frame starting at the sync bit yields words for slots 0..3 and frame_valid 32 cycles later.
- Reset mid-frame: rst pulse during slot 2 -> outputs 0 immediately, with no frame_valid. The next sync starts a clean frame that is received correctly.
- Boundary sync=0: sync absent after a frame ends -> IDLE, locked=0. Following din bits are ignored until sync arrives.
